// File: rtl/fizzbuzz_pkg.sv
// Shared types and default divisors for the fizzbuzz_stream block.
package fizzbuzz_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FB_DIV_A = 3;
  localparam int FB_DIV_B = 5;

endpackage

// File: rtl/fb_mod_counter.sv
// Residue counter modulo DIV. is_zero reports the residue that will be held
// after the current cycle's update, so callers can register flags alongside it.
module fb_mod_counter #(
  parameter int DIV = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   load_one,
  input  logic                   inc,
  output logic [$clog2(DIV)-1:0] residue,
  output logic                   is_zero
);

  localparam int RW = $clog2(DIV);

  logic [RW-1:0] residue_next;

  always_comb begin
    residue_next = residue;
    if (clear) begin
      residue_next = '0;
    end else if (load_one) begin
      residue_next = RW'(1);
    end else if (inc) begin
      residue_next = (residue == RW'(DIV - 1)) ? '0 : residue + RW'(1);
    end
  end

  assign is_zero = (residue_next == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      residue <= '0;
    end else begin
      residue <= residue_next;
    end
  end

endmodule

// File: rtl/fizzbuzz_stream.sv
// Streams 1..limit with fizz/buzz/num flags on a valid/ready interface.
// Optional per-category item counters are enabled with FIZZBUZZ_STATS_EN.
module fizzbuzz_stream
  import fizzbuzz_pkg::*;
#(
  parameter  int MAX_COUNT = 100,
  parameter  int DIV_A     = FB_DIV_A,
  parameter  int DIV_B     = FB_DIV_B,
  localparam int W         = $clog2(MAX_COUNT + 1)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] cfg_limit,
  input  logic         cfg_wrap,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] number,
  output logic         fizz,
  output logic         buzz,
  output logic         num,
`ifdef FIZZBUZZ_STATS_EN
  output logic [W-1:0] stat_fizz,
  output logic [W-1:0] stat_buzz,
  output logic [W-1:0] stat_fizzbuzz,
`endif
  output logic         busy,
  output logic         done
);

  state_t       state, state_next;
  logic [W-1:0] limit_q;
  logic         wrap_q;
  logic         start_acc, accept, last;
  logic         load_one, inc;
  logic         a_zero, b_zero;
  logic [$clog2(DIV_A)-1:0] ra;
  logic [$clog2(DIV_B)-1:0] rb;

  assign start_acc = start && (state != RUN);
  assign accept    = out_valid && out_ready;
  assign last      = (number == limit_q);
  assign load_one  = start_acc || (accept && last && wrap_q);
  assign inc       = accept && !last;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  fb_mod_counter #(.DIV(DIV_A)) u_mod_a (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (1'b0),
    .load_one (load_one),
    .inc      (inc),
    .residue  (ra),
    .is_zero  (a_zero)
  );

  fb_mod_counter #(.DIV(DIV_B)) u_mod_b (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (1'b0),
    .load_one (load_one),
    .inc      (inc),
    .residue  (rb),
    .is_zero  (b_zero)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = RUN;
      RUN:        if (accept && last && !wrap_q) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Output stage: flags are taken from the counters' post-update residues so
  // they always describe the number registered in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      limit_q   <= '0;
      wrap_q    <= 1'b0;
      number    <= '0;
      fizz      <= 1'b0;
      buzz      <= 1'b0;
      num       <= 1'b0;
      out_valid <= 1'b0;
    end else if (start_acc) begin
      limit_q   <= (cfg_limit == '0 || cfg_limit > W'(MAX_COUNT)) ? W'(MAX_COUNT) : cfg_limit;
      wrap_q    <= cfg_wrap;
      number    <= W'(1);
      fizz      <= a_zero;
      buzz      <= b_zero;
      num       <= !a_zero && !b_zero;
      out_valid <= 1'b1;
    end else if (accept) begin
      if (last && !wrap_q) begin
        out_valid <= 1'b0;
      end else begin
        number <= last ? W'(1) : number + W'(1);
        fizz   <= a_zero;
        buzz   <= b_zero;
        num    <= !a_zero && !b_zero;
      end
    end
  end

`ifdef FIZZBUZZ_STATS_EN
  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] c);
    return (c == '1) ? c : c + W'(1);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_fizz     <= '0;
      stat_buzz     <= '0;
      stat_fizzbuzz <= '0;
    end else if (start_acc) begin
      stat_fizz     <= '0;
      stat_buzz     <= '0;
      stat_fizzbuzz <= '0;
    end else if (accept) begin
      if (fizz && !buzz) stat_fizz     <= sat_inc(stat_fizz);
      if (buzz && !fizz) stat_buzz     <= sat_inc(stat_buzz);
      if (fizz && buzz)  stat_fizzbuzz <= sat_inc(stat_fizzbuzz);
    end
  end
`endif

endmodule
